// File: rtl/hwag_core.sv
// hwag_core: prescaled angle accumulator with revolution counter, compare flags and SSRAM-style register bus.
// Define HWAG_ID_REG_EN to map a read-only ID register (16'h4857) at address 0x0F.
module hwag_core #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ssram_we,
    input  logic          ssram_re,
    input  logic [AW-1:0] ssram_addr,
    inout  wire  [DW-1:0] ssram_data,
    output logic          tick_o,
    output logic          cmp0_o,
    output logic          cmp1_o
);

    localparam logic [AW-1:0] A_CTRL  = AW'(0);
    localparam logic [AW-1:0] A_PRESC = AW'(1);
    localparam logic [AW-1:0] A_STEP  = AW'(2);
    localparam logic [AW-1:0] A_AMAX  = AW'(3);
    localparam logic [AW-1:0] A_CMP0  = AW'(4);
    localparam logic [AW-1:0] A_CMP1  = AW'(5);
    localparam logic [AW-1:0] A_SCR   = AW'(6);
    localparam logic [AW-1:0] A_ANGLE = AW'(7);
    localparam logic [AW-1:0] A_REV   = AW'(8);
    localparam logic [AW-1:0] A_STAT  = AW'(9);
`ifdef HWAG_ID_REG_EN
    localparam logic [AW-1:0] A_ID    = AW'(15);
    localparam logic [DW-1:0] ID_VAL  = DW'(16'h4857);
`endif

    logic [DW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0] presc_q, presc_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] amax_q, amax_d;
    logic [DW-1:0] cmp0_q, cmp0_d;
    logic [DW-1:0] cmp1_q, cmp1_d;
    logic [DW-1:0] scr_q, scr_d;
    logic [DW-1:0] angle_q, angle_d;
    logic [DW-1:0] rev_q, rev_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [2:0]    status_q, status_d;
    logic          tick_q, tick_d;

    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          en;
    logic          tick;
    logic          clr;
    logic [DW:0]   sum;
    logic          wrap;
    logic [DW-1:0] nxt_angle;
    logic          hit0;
    logic          hit1;
    logic [2:0]    w1c;
    logic [2:0]    set;

    assign wr_en = ssram_we & ~ssram_re;
    assign rd_en = ssram_re & ~ssram_we;
    assign wdata = ssram_data;

    assign en   = ctrl_q[0];
    assign tick = en && (cnt_q >= presc_q);
    assign clr  = wr_en && (ssram_addr == A_CTRL) && wdata[1];
    assign sum  = {1'b0, angle_q} + {1'b0, step_q};

    // Programmed modulus when non-zero, otherwise the natural 16-bit carry.
    always_comb begin
        wrap      = 1'b0;
        nxt_angle = sum[DW-1:0];
        if (amax_q != '0) begin
            if (sum >= {1'b0, amax_q}) begin
                wrap      = 1'b1;
                nxt_angle = sum[DW-1:0] - amax_q;
            end
        end else begin
            wrap = sum[DW];
        end
    end

    assign cmp0_o = en && (angle_q >= cmp0_q);
    assign cmp1_o = en && (angle_q >= cmp1_q);

    // A hit is a rising compare level, or a wrap that lands at/above the compare.
    assign hit0 = (nxt_angle >= cmp0_q) && (!cmp0_o || wrap);
    assign hit1 = (nxt_angle >= cmp1_q) && (!cmp1_o || wrap);

    assign set = (tick && !clr) ? {wrap, hit1, hit0} : 3'b000;
    assign w1c = (wr_en && ssram_addr == A_STAT) ? wdata[2:0] : 3'b000;

    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        step_d   = step_q;
        amax_d   = amax_q;
        cmp0_d   = cmp0_q;
        cmp1_d   = cmp1_q;
        scr_d    = scr_q;
        angle_d  = angle_q;
        rev_d    = rev_q;
        cnt_d    = '0;
        tick_d   = tick & ~clr;
        status_d = (status_q & ~w1c) | set;

        if (clr) begin
            angle_d = '0;
            rev_d   = '0;
        end else if (tick) begin
            angle_d = nxt_angle;
            if (wrap) begin
                rev_d = rev_q + 1'b1;
            end
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (wr_en) begin
            case (ssram_addr)
                A_CTRL:  ctrl_d  = {wdata[DW-1:2], 1'b0, wdata[0]};
                A_PRESC: presc_d = wdata;
                A_STEP:  step_d  = wdata;
                A_AMAX:  amax_d  = wdata;
                A_CMP0:  cmp0_d  = wdata;
                A_CMP1:  cmp1_d  = wdata;
                A_SCR:   scr_d   = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            presc_q  <= '0;
            step_q   <= '0;
            amax_q   <= '0;
            cmp0_q   <= '0;
            cmp1_q   <= '0;
            scr_q    <= '0;
            angle_q  <= '0;
            rev_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            amax_q   <= amax_d;
            cmp0_q   <= cmp0_d;
            cmp1_q   <= cmp1_d;
            scr_q    <= scr_d;
            angle_q  <= angle_d;
            rev_q    <= rev_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o = tick_q;

    always_comb begin
        rdata = '0;
        case (ssram_addr)
            A_CTRL:  rdata = ctrl_q;
            A_PRESC: rdata = presc_q;
            A_STEP:  rdata = step_q;
            A_AMAX:  rdata = amax_q;
            A_CMP0:  rdata = cmp0_q;
            A_CMP1:  rdata = cmp1_q;
            A_SCR:   rdata = scr_q;
            A_ANGLE: rdata = angle_q;
            A_REV:   rdata = rev_q;
            A_STAT:  rdata = {{(DW-3){1'b0}}, status_q};
`ifdef HWAG_ID_REG_EN
            A_ID:    rdata = ID_VAL;
`endif
            default: rdata = '0;
        endcase
    end

    assign ssram_data = rd_en ? rdata : {DW{1'bz}};

endmodule

// File: tb/tb_hwag_core.sv
// tb_hwag_core: directed table, multi-cycle sequences and randomized run
// against a behavioural model of the angle generator.
module tb_hwag_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic        drv;
    logic [15:0] wdat;
    wire  [15:0] bus;
    logic        tick;
    logic        c0;
    logic        c1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef HWAG_ID_REG_EN
    localparam logic [15:0] ID_EXP = 16'h4857;
`else
    localparam logic [15:0] ID_EXP = 16'h0000;
`endif

    // Undriven bus floats high, so a released bus reads 16'hFFFF.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (bus[g]);
    end
    assign bus = drv ? wdat : 16'hzzzz;

    always #5 clk = ~clk;

    hwag_core dut (
        .clk        (clk),
        .rst        (rst),
        .ssram_we   (we),
        .ssram_re   (re),
        .ssram_addr (addr),
        .ssram_data (bus),
        .tick_o     (tick),
        .cmp0_o     (c0),
        .cmp1_o     (c1)
    );

    // Behavioural reference: register array plus angle/revolution state.
    logic [15:0] m_reg [0:6];
    logic [15:0] m_ang;
    logic [15:0] m_rev;
    logic [15:0] m_cnt;
    logic [2:0]  m_st;
    logic        m_tick;

    always @(posedge clk) begin : model
        int       nxt;
        bit       wr, tk, clr, wrp, h0, h1;
        logic [2:0] w1c;
        if (rst) begin
            for (int i = 0; i < 7; i++) m_reg[i] <= 16'h0;
            m_ang  <= 16'h0;
            m_rev  <= 16'h0;
            m_cnt  <= 16'h0;
            m_st   <= 3'b0;
            m_tick <= 1'b0;
        end else begin
            wr  = we && !re;
            tk  = m_reg[0][0] && (m_cnt >= m_reg[1]);
            clr = wr && addr == 8'd0 && bus[1];
            nxt = int'(m_ang) + int'(m_reg[2]);
            wrp = 1'b0;
            if (m_reg[3] != 16'h0) begin
                if (nxt >= int'(m_reg[3])) begin
                    nxt = nxt - int'(m_reg[3]);
                    wrp = 1'b1;
                end
            end else if (nxt > 65535) begin
                nxt = nxt - 65536;
                wrp = 1'b1;
            end
            nxt = nxt & 32'hFFFF;
            h0 = tk && !clr && nxt >= int'(m_reg[4]) && (m_ang < m_reg[4] || wrp);
            h1 = tk && !clr && nxt >= int'(m_reg[5]) && (m_ang < m_reg[5] || wrp);
            w1c = (wr && addr == 8'd9) ? bus[2:0] : 3'b0;
            m_st   <= (m_st & ~w1c) | {tk && !clr && wrp, h1, h0};
            m_tick <= tk && !clr;
            if (clr) begin
                m_ang <= 16'h0;
                m_rev <= 16'h0;
                m_cnt <= 16'h0;
            end else if (tk) begin
                m_ang <= nxt[15:0];
                m_rev <= m_rev + (wrp ? 16'd1 : 16'd0);
                m_cnt <= 16'h0;
            end else begin
                m_cnt <= m_reg[0][0] ? m_cnt + 16'd1 : 16'h0;
            end
            if (wr && addr <= 8'd6)
                m_reg[addr[2:0]] <= (addr == 8'd0) ? (bus & 16'hFFFD) : bus;
        end
    end

    function automatic logic [15:0] m_rd(input logic [7:0] a);
        if (a <= 8'd6) return m_reg[a[2:0]];
        if (a == 8'd7) return m_ang;
        if (a == 8'd8) return m_rev;
        if (a == 8'd9) return {13'b0, m_st};
        if (a == 8'd15) return ID_EXP;
        return 16'h0;
    endfunction

    function automatic logic [15:0] rnd_data(input logic [7:0] a);
        logic [15:0] d;
        d = 16'($urandom);
        case (a)
            8'd0: begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 15) == 0);
            end
            8'd1: d = 16'($urandom_range(0, 3));
            8'd2: d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600));
            8'd3: d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 2000));
            8'd4, 8'd5: d = 16'($urandom_range(0, 2200));
            8'd9: d = 16'($urandom_range(0, 7));
            default: ;
        endcase
        return d;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Combinational read inside the current low phase; no clock edge crossed.
    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        addr = a;
        we   = 1'b0;
        re   = 1'b1;
        #1;
        d  = bus;
        re = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a;
        wdat = d;
        drv  = 1'b1;
        re   = 1'b0;
        we   = 1'b1;
        @(negedge clk);
        we  = 1'b0;
        drv = 1'b0;
    endtask

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] e;
    } vec_t;

    vec_t        tv[$];
    logic [15:0] v;
    logic [15:0] exp_rd  [8] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd0};
    logic [15:0] exp_ang [5] = '{16'd4, 16'd8, 16'd2, 16'd6, 16'd0};
    int          n;
    int          op;

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        re   = 1'b0;
        addr = 8'h0;
        drv  = 1'b0;
        wdat = 16'h0;
        repeat (3) @(negedge clk);

        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rd(8'(a), v);
            chk($sformatf("rst_rd%0d", a), v, (a == 15) ? ID_EXP : 16'h0);
        end
        #1;
        chk("rst_z", bus, 16'hFFFF);
        chk("rst_tick", {15'b0, tick}, 16'h0);
        chk("rst_cmp", {14'b0, c1, c0}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            tv.push_back('{w: 1'b1, a: 8'(i), d: 16'(2 * i), e: 16'h0});
        for (int i = 0; i < 8; i++)
            tv.push_back('{w: 1'b0, a: 8'(i), d: 16'h0, e: exp_rd[i]});
        tv.push_back('{w: 1'b0, a: 8'd8,  d: 16'h0, e: 16'h0});
        tv.push_back('{w: 1'b0, a: 8'd9,  d: 16'h0, e: 16'h0});
        tv.push_back('{w: 1'b0, a: 8'd10, d: 16'h0, e: 16'h0});
        tv.push_back('{w: 1'b0, a: 8'd15, d: 16'h0, e: ID_EXP});
        tv.push_back('{w: 1'b1, a: 8'd15, d: 16'hBEEF, e: 16'h0});
        tv.push_back('{w: 1'b0, a: 8'd15, d: 16'h0, e: ID_EXP});
        tv.push_back('{w: 1'b1, a: 8'd12, d: 16'hBEEF, e: 16'h0});
        tv.push_back('{w: 1'b0, a: 8'd12, d: 16'h0, e: 16'h0});
        foreach (tv[i]) begin
            if (tv[i].w) begin
                wr(tv[i].a, tv[i].d);
            end else begin
                @(negedge clk);
                rd(tv[i].a, v);
                chk($sformatf("tbl_rd%0d", tv[i].a), v, tv[i].e);
            end
        end

        wr(8'd1, 16'd2);
        wr(8'd2, 16'd4);
        wr(8'd3, 16'd10);
        wr(8'd4, 16'd5);
        wr(8'd5, 16'hFFFF);
        wr(8'd0, 16'd1);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (tick || n >= 10) break;
            end
            chk($sformatf("tick_gap%0d", k), 16'(n), 16'd3);
            rd(8'd7, v);
            chk($sformatf("angle%0d", k), v, exp_ang[k]);
            if (k == 0) chk("cmp0_lo", {15'b0, c0}, 16'h0);
            if (k == 1) begin
                chk("cmp0_hi", {15'b0, c0}, 16'h1);
                rd(8'd9, v);
                chk("stat_hit0", v, 16'h1);
            end
        end
        @(negedge clk);
        rd(8'd8, v);
        chk("revcnt", v, 16'd2);
        rd(8'd9, v);
        chk("stat_wrap", v, 16'h5);
        wr(8'd9, 16'h1);
        rd(8'd9, v);
        chk("stat_w1c", v, 16'h4);

        wr(8'd0, 16'd3);
        rd(8'd7, v);
        chk("clr_angle", v, 16'h0);
        rd(8'd8, v);
        chk("clr_rev", v, 16'h0);
        @(negedge clk);
        rd(8'd0, v);
        chk("clr_ctrl", v, 16'h1);
        rd(8'd9, v);
        chk("clr_stat", v, 16'h4);

        wr(8'd6, 16'h1234);
        @(negedge clk);
        addr = 8'd6;
        drv  = 1'b0;
        we   = 1'b1;
        re   = 1'b1;
        #1;
        chk("wrre_z", bus, 16'hFFFF);
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        rd(8'd6, v);
        chk("wrre_scr", v, 16'h1234);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            we  = 1'b0;
            re  = 1'b0;
            drv = 1'b0;
            rst = (i == 700);
            op  = $urandom_range(0, 9);
            addr = 8'($urandom_range(0, 15));
            if (!rst && op < 3) begin
                wdat = rnd_data(addr);
                drv  = 1'b1;
                we   = 1'b1;
            end else if (!rst && op < 6) begin
                re = 1'b1;
            end else if (!rst && op == 6) begin
                we = 1'b1;
                re = 1'b1;
            end
            #1;
            chk("r_tick", {15'b0, tick}, {15'b0, m_tick});
            chk("r_cmp0", {15'b0, c0}, {15'b0, m_reg[0][0] && m_ang >= m_reg[4]});
            chk("r_cmp1", {15'b0, c1}, {15'b0, m_reg[0][0] && m_ang >= m_reg[5]});
            if (re && !we) chk($sformatf("r_rd%0d", addr), bus, m_rd(addr));
            else if (!drv) chk("r_z", bus, 16'hFFFF);
        end

        @(negedge clk);
        we  = 1'b0;
        re  = 1'b0;
        drv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(8'd7, v);
        chk("end_rst_angle", v, 16'h0);
        rd(8'd0, v);
        chk("end_rst_ctrl", v, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
